// File: rtl/printer_model.sv
// Printer endpoint for the 8-bit parallel output controller: rdy handshake,
// fixed print time per character, line buffer, counters, checksum and protocol-error flag.
module printer_model #(
    parameter int unsigned PRINT_CYCLES = 8,
    parameter int unsigned LINE_LEN     = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_tr,
    input  logic [7:0]                  i_pd,
    input  logic [$clog2(LINE_LEN)-1:0] i_rd_idx,
    output logic                        o_rdy,
    output logic [7:0]                  o_rd_data,
    output logic [7:0]                  o_last_char,
    output logic [15:0]                 o_char_cnt,
    output logic [7:0]                  o_line_cnt,
    output logic                        o_line_done,
    output logic [$clog2(LINE_LEN):0]   o_line_len,
    output logic [7:0]                  o_checksum,
    output logic                        o_proto_err
);

    localparam int unsigned IDX_W  = $clog2(LINE_LEN);
    localparam int unsigned LEN_W  = IDX_W + 1;
    localparam int unsigned BUSY_W = 8;
    localparam logic [7:0]  LF     = 8'h0A;

    typedef enum logic {IDLE, PRINT} state_t;

    state_t             state, state_nxt;
    logic [BUSY_W-1:0]  busy, busy_nxt;
    logic               armed, armed_nxt;
    logic               tr_prev;
    logic [IDX_W-1:0]   wr_ptr, wr_ptr_nxt;
    logic               rdy_nxt;
    logic [7:0]         last_char_nxt;
    logic [15:0]        char_cnt_nxt;
    logic [7:0]         line_cnt_nxt;
    logic               line_done_nxt;
    logic [LEN_W-1:0]   line_len_nxt;
    logic [7:0]         checksum_nxt;
    logic               proto_err_nxt;
    logic               accept;
    logic               line_end;
    logic [7:0]         line_buf [LINE_LEN];

    // State and status registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            busy        <= '0;
            armed       <= 1'b0;
            tr_prev     <= 1'b0;
            wr_ptr      <= '0;
            o_rdy       <= 1'b1;
            o_last_char <= '0;
            o_char_cnt  <= '0;
            o_line_cnt  <= '0;
            o_line_done <= 1'b0;
            o_line_len  <= '0;
            o_checksum  <= '0;
            o_proto_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= busy_nxt;
            armed       <= armed_nxt;
            tr_prev     <= i_tr;
            wr_ptr      <= wr_ptr_nxt;
            o_rdy       <= rdy_nxt;
            o_last_char <= last_char_nxt;
            o_char_cnt  <= char_cnt_nxt;
            o_line_cnt  <= line_cnt_nxt;
            o_line_done <= line_done_nxt;
            o_line_len  <= line_len_nxt;
            o_checksum  <= checksum_nxt;
            o_proto_err <= proto_err_nxt;
        end
    end

    // Next-state, accept and line-completion logic
    always_comb begin
        state_nxt     = state;
        busy_nxt      = busy;
        armed_nxt     = armed;
        wr_ptr_nxt    = wr_ptr;
        last_char_nxt = o_last_char;
        char_cnt_nxt  = o_char_cnt;
        line_cnt_nxt  = o_line_cnt;
        line_done_nxt = 1'b0;
        line_len_nxt  = o_line_len;
        checksum_nxt  = o_checksum;
        proto_err_nxt = o_proto_err;
        accept        = 1'b0;
        line_end      = 1'b0;

        if (!i_tr) begin
            armed_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (i_tr && armed) begin
                    accept        = 1'b1;
                    armed_nxt     = 1'b0;
                    state_nxt     = PRINT;
                    busy_nxt      = BUSY_W'(PRINT_CYCLES - 1);
                    last_char_nxt = i_pd;
                    char_cnt_nxt  = o_char_cnt + 16'd1;
                    checksum_nxt  = o_checksum + i_pd;
                    // LF in the last slot is still one completion
                    line_end      = (i_pd == LF) || (wr_ptr == IDX_W'(LINE_LEN - 1));
                    if (line_end) begin
                        line_len_nxt  = LEN_W'(wr_ptr) + LEN_W'(1);
                        wr_ptr_nxt    = '0;
                        line_cnt_nxt  = o_line_cnt + 8'd1;
                        line_done_nxt = 1'b1;
                    end else begin
                        wr_ptr_nxt = wr_ptr + IDX_W'(1);
                    end
                end
            end
            PRINT: begin
                if (i_tr && !tr_prev) begin
                    proto_err_nxt = 1'b1;
                end
                if (busy == '0) begin
                    state_nxt = IDLE;
                end else begin
                    busy_nxt = busy - BUSY_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        rdy_nxt = (state_nxt == IDLE);
    end

    // Line buffer storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < LINE_LEN; i++) begin
                line_buf[i] <= '0;
            end
        end else if (accept) begin
            line_buf[wr_ptr] <= i_pd;
        end
    end

    assign o_rd_data = line_buf[i_rd_idx];

endmodule

// File: tb/tb_printer_model.sv
// Self-checking bench for printer_model: directed scenarios plus random traffic
// against a transaction-level model of the printer.
module tb_printer_model;

    localparam int unsigned P  = 8;
    localparam int unsigned L  = 16;
    localparam int unsigned IW = $clog2(L);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tr = 1'b0;
    logic [7:0]    pd = 8'h00;
    logic [IW-1:0] rd_idx = '0;

    logic          o_rdy;
    logic [7:0]    o_rd_data;
    logic [7:0]    o_last_char;
    logic [15:0]   o_char_cnt;
    logic [7:0]    o_line_cnt;
    logic          o_line_done;
    logic [IW:0]   o_line_len;
    logic [7:0]    o_checksum;
    logic          o_proto_err;

    printer_model #(.PRINT_CYCLES(P), .LINE_LEN(L)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tr        (tr),
        .i_pd        (pd),
        .i_rd_idx    (rd_idx),
        .o_rdy       (o_rdy),
        .o_rd_data   (o_rd_data),
        .o_last_char (o_last_char),
        .o_char_cnt  (o_char_cnt),
        .o_line_cnt  (o_line_cnt),
        .o_line_done (o_line_done),
        .o_line_len  (o_line_len),
        .o_checksum  (o_checksum),
        .o_proto_err (o_proto_err)
    );

    always #5 clk = ~clk;

    // Model: remaining print time, arm flag, current line as a queue
    int         m_low;
    bit         m_armed;
    bit         m_trp;
    int         m_last, m_cc, m_lc, m_ll, m_cs;
    bit         m_done, m_err;
    logic [7:0] m_mem [L];
    logic [7:0] m_line [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_low = 0; m_armed = 0; m_trp = 0;
        m_last = 0; m_cc = 0; m_lc = 0; m_ll = 0; m_cs = 0;
        m_done = 0; m_err = 0;
        for (int i = 0; i < L; i++) m_mem[i] = 8'h00;
        m_line.delete();
    endfunction

    function automatic void model_edge();
        bit acc;
        acc = 0;
        m_done = 0;
        if (m_low == 0) begin
            if (tr && m_armed) begin
                acc = 1;
                m_last = pd;
                m_cc = (m_cc + 1) % 65536;
                m_cs = (m_cs + pd) % 256;
                m_mem[m_line.size()] = pd;
                m_line.push_back(pd);
                if (pd == 8'h0A || m_line.size() == L) begin
                    m_ll = m_line.size();
                    m_line.delete();
                    m_lc = (m_lc + 1) % 256;
                    m_done = 1;
                end
                m_low = P;
            end
        end else begin
            if (tr && !m_trp) m_err = 1;
            m_low--;
        end
        if (acc) m_armed = 0;
        else if (!tr) m_armed = 1;
        m_trp = tr;
    endfunction

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("rdy",       o_rdy,       (m_low == 0));
        check("rd_data",   o_rd_data,   m_mem[rd_idx]);
        check("last_char", o_last_char, m_last);
        check("char_cnt",  o_char_cnt,  m_cc);
        check("line_cnt",  o_line_cnt,  m_lc);
        check("line_done", o_line_done, m_done);
        check("line_len",  o_line_len,  m_ll);
        check("checksum",  o_checksum,  m_cs);
        check("proto_err", o_proto_err, m_err);
    end

    task automatic step(input logic t, input logic [7:0] d);
        tr = t;
        pd = d;
        rd_idx = IW'($urandom_range(0, L - 1));
        @(posedge clk);
        if (rst_n) model_edge();
        #2;
    endtask

    task automatic send(input logic [7:0] ch);
        step(1'b1, ch);
        repeat (P) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rdy", o_rdy, 1);
        check("rst_cnt", o_char_cnt, 0);
        #10;
        rst_n = 1'b1;
        step(1'b0, 8'h00);
    endtask

    initial begin
        model_reset();
        #12;
        check("init_rdy", o_rdy, 1);
        check("init_cnt", o_char_cnt, 0);
        check("init_err", o_proto_err, 0);
        rst_n = 1'b1;

        // Single character and held strobe
        step(1'b0, 8'h00);
        step(1'b1, 8'h41);
        check("single_rdy_low", o_rdy, 0);
        check("single_last", o_last_char, 8'h41);
        check("single_cnt", o_char_cnt, 1);
        check("single_cs", o_checksum, 8'h41);
        rd_idx = '0;
        #1;
        check("single_buf0", o_rd_data, 8'h41);
        repeat (P - 1) step(1'b1, 8'h00);
        check("rdy_still_low", o_rdy, 0);
        step(1'b1, 8'h00);
        check("rdy_back", o_rdy, 1);
        repeat (4) step(1'b1, 8'h00);
        check("held_cnt", o_char_cnt, 1);
        check("held_err", o_proto_err, 0);
        step(1'b0, 8'h00);
        step(1'b1, 8'h42);
        check("second_cnt", o_char_cnt, 2);
        check("second_cs", o_checksum, 8'h83);
        repeat (P) step(1'b0, 8'h00);

        // Newline-terminated line
        do_reset();
        send(8'h48);
        send(8'h49);
        step(1'b1, 8'h0A);
        check("hi_done", o_line_done, 1);
        check("hi_len", o_line_len, 3);
        check("hi_lines", o_line_cnt, 1);
        step(1'b0, 8'h00);
        check("hi_done_drop", o_line_done, 0);
        repeat (P - 1) step(1'b0, 8'h00);
        send(8'h78);
        rd_idx = '0;
        #1;
        check("hi_next_idx0", o_rd_data, 8'h78);

        // Full line, then LF in the last slot
        do_reset();
        for (int i = 0; i < 16; i++) send(8'h61 + 8'(i));
        check("full_len", o_line_len, 16);
        check("full_lines", o_line_cnt, 1);
        for (int i = 0; i < 15; i++) send(8'h30 + 8'(i));
        send(8'h0A);
        check("lf_last_lines", o_line_cnt, 2);
        check("lf_last_len", o_line_len, 16);

        // Protocol error during print
        step(1'b1, 8'h70);
        step(1'b0, 8'h00);
        step(1'b1, 8'h71);
        step(1'b0, 8'h00);
        check("perr_set", o_proto_err, 1);
        check("perr_cnt", o_char_cnt, 33);
        check("perr_rdy", o_rdy, 0);
        repeat (P - 3) step(1'b0, 8'h00);
        check("perr_rdy_back", o_rdy, 1);
        check("perr_last", o_last_char, 8'h70);
        check("perr_sticky", o_proto_err, 1);

        // Reset in the middle of a print with strobe held high
        step(1'b1, 8'h72);
        repeat (3) step(1'b1, 8'h00);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_rdy", o_rdy, 1);
        check("mid_rst_cnt", o_char_cnt, 0);
        check("mid_rst_cs", o_checksum, 0);
        check("mid_rst_err", o_proto_err, 0);
        #10;
        rst_n = 1'b1;
        repeat (5) step(1'b1, 8'h00);
        check("post_rst_noacc", o_char_cnt, 0);
        step(1'b0, 8'h00);
        step(1'b1, 8'h73);
        check("post_rst_acc", o_char_cnt, 1);
        check("post_rst_last", o_last_char, 8'h73);
        repeat (P) step(1'b0, 8'h00);

        // Line counter wrap
        do_reset();
        repeat (256) send(8'h0A);
        check("wrap_lines", o_line_cnt, 0);
        check("wrap_chars", o_char_cnt, 256);
        check("wrap_cs", o_checksum, 0);
        check("wrap_len", o_line_len, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step(1'b0, 8'h00);
                rst_n = 1'b1;
            end else begin
                logic       t;
                logic [7:0] d;
                t = ($urandom_range(0, 2) == 0) ? ~tr : tr;
                d = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
                step(t, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
